// File: rtl/display_scan6.sv
`default_nettype none
// ============================================================================
// Module      : display_scan6
// Description : Six-digit multiplexed 7-segment scanner for a BCD HH:MM:SS
//               clock. It takes a snapshot of the time once per frame so the
//               digits shown in one frame always come from the same time
//               value. It drives one digit per slot, with one blank cycle at
//               the start of each slot to suppress ghosting. All outputs are
//               registered.
// Options     : `define DISPLAY_LZB_EN blanks the hour-tens digit when it is
//               zero. Scan timing does not change, because the digit enable
//               is still driven.
// Revision    : 1.0 - initial release
// ============================================================================
module display_scan6 #(
  parameter int SCAN_DIV = 4            // CP cycles per digit slot, 2..255
) (
  input  logic       CP,
  input  logic       CR,
  input  logic [7:0] Hour,
  input  logic [7:0] Minute,
  input  logic [7:0] Second,
  input  logic       ColonIn,
  output logic [6:0] Seg,
  output logic       DP,
  output logic [5:0] DigSel,
  output logic       FrameStart
);

  localparam logic [7:0] CNT_LAST = 8'(SCAN_DIV - 1);
  localparam logic [2:0] IDX_LAST = 3'd5;
  localparam logic [5:0] DIG_NONE = 6'b111111;

  // Segment patterns {g,f,e,d,c,b,a}; anything that is not a decimal digit shows '-'
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'd0:    pat = 7'h3F;
      4'd1:    pat = 7'h06;
      4'd2:    pat = 7'h5B;
      4'd3:    pat = 7'h4F;
      4'd4:    pat = 7'h66;
      4'd5:    pat = 7'h6D;
      4'd6:    pat = 7'h7D;
      4'd7:    pat = 7'h07;
      4'd8:    pat = 7'h7F;
      4'd9:    pat = 7'h6F;
      default: pat = 7'h40;
    endcase
    return pat;
  endfunction

  logic [7:0]  cnt;
  logic [2:0]  idx;
  logic [23:0] snapshot;

  logic [7:0]  cnt_next;
  logic [2:0]  idx_next;
  logic        frame_slot;
  logic        blank_slot;
  logic [3:0]  nibble;
  logic [6:0]  seg_active;
  logic [5:0]  dig_active;
  logic        dp_active;

  // Slot/digit counters: cnt steps through one slot, and idx moves to the next digit when cnt wraps
  always_comb begin
    cnt_next = cnt + 8'd1;
    idx_next = idx;
    if (cnt == CNT_LAST) begin
      cnt_next = 8'd0;
      idx_next = (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
    end
  end

  // Decode the current state into the values the output registers load next
  always_comb begin
    frame_slot = (idx == 3'd0) && (cnt == 8'd0);
    blank_slot = (cnt == 8'd0);

    case (idx)
      3'd0:    nibble = snapshot[23:20];
      3'd1:    nibble = snapshot[19:16];
      3'd2:    nibble = snapshot[15:12];
      3'd3:    nibble = snapshot[11:8];
      3'd4:    nibble = snapshot[7:4];
      3'd5:    nibble = snapshot[3:0];
      default: nibble = 4'd0;
    endcase

    seg_active = seg_decode(nibble);
`ifdef DISPLAY_LZB_EN
    // A leading zero on the hour tens digit is left dark, but the digit is still enabled
    if ((idx == 3'd0) && (nibble == 4'd0)) begin
      seg_active = 7'h00;
    end
`endif

    dig_active = ~(6'b000001 << idx);
    // The decimal points after the hour-ones and minute-ones digits act as the colons
    dp_active  = ColonIn && ((idx == 3'd1) || (idx == 3'd3));
  end

  // Sequencer state and the once-per-frame time snapshot
  always_ff @(posedge CP) begin
    if (CR) begin
      cnt      <= 8'd0;
      idx      <= 3'd0;
      snapshot <= 24'h0;
    end else begin
      cnt <= cnt_next;
      idx <= idx_next;
      if (frame_slot) begin
        snapshot <= {Hour, Minute, Second};
      end
    end
  end

  // Registered pin drivers, one cycle behind the sequencer state
  always_ff @(posedge CP) begin
    if (CR) begin
      Seg        <= 7'h00;
      DP         <= 1'b0;
      DigSel     <= DIG_NONE;
      FrameStart <= 1'b0;
    end else begin
      FrameStart <= frame_slot;
      if (blank_slot) begin
        Seg    <= 7'h00;
        DP     <= 1'b0;
        DigSel <= DIG_NONE;
      end else begin
        Seg    <= seg_active;
        DP     <= dp_active;
        DigSel <= dig_active;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_display_scan6.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_scan6
// Description : Self-checking bench for display_scan6. The reference model
//               works out each expected output from the cycle's position in
//               the frame and from a time value captured at each frame start.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_scan6;

  localparam int SD    = 4;
  localparam int FRAME = 6 * SD;
  localparam logic [6:0] SEG_TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                          7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic       clk = 1'b0;
  logic       cr = 1'b1;
  logic [7:0] hour = 8'h00;
  logic [7:0] minute = 8'h00;
  logic [7:0] second = 8'h00;
  logic       colon = 1'b0;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] digsel;
  logic       fs;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          k = 0;               // non-reset cycles since the last clear
  logic [23:0] msnap = 24'h0;
  logic [6:0]  exp_seg;
  logic        exp_dp;
  logic [5:0]  exp_dig;
  logic        exp_fs;

  display_scan6 #(.SCAN_DIV(SD)) dut (
    .CP(clk), .CR(cr), .Hour(hour), .Minute(minute), .Second(second),
    .ColonIn(colon), .Seg(seg), .DP(dp), .DigSel(digsel), .FrameStart(fs)
  );

  always #5 clk = ~clk;

  // Advance one clock and compute what the outputs must show after that edge
  task automatic tick();
    int s, slot, pos;
    logic [3:0] nib;
    @(posedge clk);
    if (cr) begin
      exp_seg = 7'h00; exp_dp = 1'b0; exp_dig = 6'h3F; exp_fs = 1'b0;
      k = 0; msnap = 24'h0;
    end else begin
      s    = k % FRAME;
      slot = s / SD;
      pos  = s % SD;
      if (s == 0) msnap = {hour, minute, second};
      exp_fs = (s == 0);
      if (pos == 0) begin
        exp_seg = 7'h00; exp_dp = 1'b0; exp_dig = 6'h3F;
      end else begin
        nib = msnap[23 - 4*slot -: 4];
        exp_seg = (nib > 4'd9) ? 7'h40 : SEG_TAB[nib];
`ifdef DISPLAY_LZB_EN
        if (slot == 0 && nib == 4'd0) exp_seg = 7'h00;
`endif
        exp_dig = 6'h3F;
        exp_dig[slot] = 1'b0;
        exp_dp = colon && (slot == 1 || slot == 3);
      end
      k++;
    end
    #1;
  endtask

  task automatic restart();
    cr = 1'b1;
    tick();
    cr = 1'b0;
  endtask

  task automatic test_reset();
    hour = 8'h23; minute = 8'h45; second = 8'h67;
    cr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({seg, dp, digsel, fs} !== {7'h00, 1'b0, 6'h3F, 1'b0}) begin
        errors++;
        $display("FAIL reset_hold cyc %0d: seg=%h dp=%b dig=%h fs=%b, want 00/0/3f/0", i, seg, dp, digsel, fs);
      end
    end
    cr = 1'b0;
    tick();
    checks++;
    if (fs !== 1'b1 || digsel !== 6'h3F) begin
      errors++;
      $display("FAIL reset_release: fs=%b dig=%h, want 1/3f", fs, digsel);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (digsel !== 6'h3E || seg !== 7'h5B) begin
        errors++;
        $display("FAIL reset_first_digit cyc %0d: dig=%h seg=%h, want 3e/5b", i, digsel, seg);
      end
    end
  endtask

  task automatic test_full_frame();
    logic [6:0] got [$];
    logic [6:0] want [6];
    int fs_count;
    want = '{7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07};
    hour = 8'h23; minute = 8'h45; second = 8'h67; colon = 1'b0;
    restart();
    fs_count = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      checks++;
      if ({seg, dp, digsel, fs} !== {exp_seg, exp_dp, exp_dig, exp_fs}) begin
        errors++;
        $display("FAIL full_frame cyc %0d: seg=%h dp=%b dig=%h fs=%b, want %h/%b/%h/%b",
                 i, seg, dp, digsel, fs, exp_seg, exp_dp, exp_dig, exp_fs);
      end
      if (fs) fs_count++;
      if (i < FRAME && (i % SD) == 1) got.push_back(seg);
    end
    checks++;
    if (fs_count !== 2) begin
      errors++;
      $display("FAIL frame_start_count: got %0d, want 2", fs_count);
    end
    for (int d = 0; d < 6; d++) begin
      checks++;
      if (got[d] !== want[d]) begin
        errors++;
        $display("FAIL digit_seq idx%0d: seg=%h, want %h", d, got[d], want[d]);
      end
    end
  endtask

  task automatic test_tear_free();
    logic [6:0] sec_ones_a, sec_ones_b;
    hour = 8'h12; minute = 8'h59; second = 8'h59;
    restart();
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      if (i == 2 * SD + 1) begin
        hour = 8'h13; minute = 8'h00; second = 8'h00;
      end
      if (i == 5 * SD + 1) sec_ones_a = seg;
      if (i == FRAME + 5 * SD + 1) sec_ones_b = seg;
      checks++;
      if ({seg, dp, digsel, fs} !== {exp_seg, exp_dp, exp_dig, exp_fs}) begin
        errors++;
        $display("FAIL tear_free cyc %0d: seg=%h dig=%h fs=%b, want %h/%h/%b",
                 i, seg, digsel, fs, exp_seg, exp_dig, exp_fs);
      end
    end
    checks++;
    if (sec_ones_a !== 7'h6F || sec_ones_b !== 7'h3F) begin
      errors++;
      $display("FAIL tear_sec_ones: frame1=%h frame2=%h, want 6f/3f", sec_ones_a, sec_ones_b);
    end
  endtask

  task automatic test_invalid_bcd();
    logic [6:0] m_tens, m_ones;
    hour = 8'h01; minute = 8'hA9; second = 8'hFC;
    restart();
    for (int i = 0; i < FRAME; i++) begin
      tick();
      if (i == 2 * SD + 1) m_tens = seg;
      if (i == 3 * SD + 1) m_ones = seg;
      checks++;
      if ({seg, dp, digsel, fs} !== {exp_seg, exp_dp, exp_dig, exp_fs}) begin
        errors++;
        $display("FAIL invalid_bcd cyc %0d: seg=%h dig=%h, want %h/%h", i, seg, digsel, exp_seg, exp_dig);
      end
    end
    checks++;
    if (m_tens !== 7'h40 || m_ones !== 7'h6F) begin
      errors++;
      $display("FAIL invalid_minute: tens=%h ones=%h, want 40/6f", m_tens, m_ones);
    end
  endtask

  task automatic test_colon();
    int dp_hits;
    hour = 8'h10; minute = 8'h20; second = 8'h30;
    restart();
    for (int pass = 0; pass < 2; pass++) begin
      colon = (pass == 0);
      dp_hits = 0;
      for (int i = 0; i < FRAME; i++) begin
        tick();
        if (dp) dp_hits++;
        checks++;
        if ({seg, dp, digsel, fs} !== {exp_seg, exp_dp, exp_dig, exp_fs}) begin
          errors++;
          $display("FAIL colon pass %0d cyc %0d: dp=%b dig=%h, want %b/%h", pass, i, dp, digsel, exp_dp, exp_dig);
        end
      end
      checks++;
      if (dp_hits !== ((pass == 0) ? 2 * (SD - 1) : 0)) begin
        errors++;
        $display("FAIL colon_count pass %0d: got %0d", pass, dp_hits);
      end
    end
  endtask

  task automatic test_midframe_reset();
    hour = 8'h09; minute = 8'h34; second = 8'h56; colon = 1'b1;
    restart();
    for (int i = 0; i <= 4 * SD + 1; i++) tick();
    cr = 1'b1;
    tick();
    checks++;
    if ({seg, dp, digsel, fs} !== {7'h00, 1'b0, 6'h3F, 1'b0}) begin
      errors++;
      $display("FAIL midframe_reset: seg=%h dp=%b dig=%h fs=%b, want 00/0/3f/0", seg, dp, digsel, fs);
    end
    cr = 1'b0;
    tick();
    checks++;
    if (fs !== 1'b1 || digsel !== 6'h3F) begin
      errors++;
      $display("FAIL midframe_restart: fs=%b dig=%h, want 1/3f", fs, digsel);
    end
    tick();
    checks++;
`ifdef DISPLAY_LZB_EN
    if (digsel !== 6'h3E || seg !== 7'h00) begin
      errors++;
      $display("FAIL lzb_hour_tens: dig=%h seg=%h, want 3e/00", digsel, seg);
    end
`else
    if (digsel !== 6'h3E || seg !== 7'h3F) begin
      errors++;
      $display("FAIL lzb_hour_tens: dig=%h seg=%h, want 3e/3f", digsel, seg);
    end
`endif
  endtask

  task automatic test_random();
    logic [5:0] prev_dig = 6'h3F;
    restart();
    for (int i = 0; i < 8 * FRAME; i++) begin
      if ($urandom_range(7) == 0) hour   = 8'($urandom);
      if ($urandom_range(7) == 0) minute = 8'($urandom);
      if ($urandom_range(7) == 0) second = 8'($urandom);
      if ($urandom_range(3) == 0) colon  = 1'($urandom);
      tick();
      checks++;
      if ({seg, dp, digsel, fs} !== {exp_seg, exp_dp, exp_dig, exp_fs}) begin
        errors++;
        $display("FAIL random cyc %0d: seg=%h dp=%b dig=%h fs=%b, want %h/%b/%h/%b",
                 i, seg, dp, digsel, fs, exp_seg, exp_dp, exp_dig, exp_fs);
      end
      checks++;
      if (prev_dig != 6'h3F && digsel != 6'h3F && digsel != prev_dig) begin
        errors++;
        $display("FAIL digsel_no_blank cyc %0d: %h -> %h, want blank 3f between", i, prev_dig, digsel);
      end
      prev_dig = digsel;
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_tear_free();
    test_invalid_bcd();
    test_colon();
    test_midframe_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
